// File: rtl/instr_prefetch_buffer.sv
// instr_prefetch_buffer: sequential instruction prefetch FIFO between Fetch and the memory controller
//
// Ports:
//   clock, reset        rising-edge clock; asynchronous active-low reset
//   fe_pb_req/pc        Fetch asks for the instruction at fe_pb_pc this cycle
//   fe_pb_redirect      PC discontinuity, restart prefetching at fe_pb_pc
//   pb_fe_valid/instr   combinational hit: head entry matches fe_pb_pc
//   pb_mc_en/addr       read request to the controller, held until mc_pb_ack
//   mc_pb_data/ack      read data and one-cycle completion pulse
//   mem_pb_busy         Memory stage owns the controller; no new request may start
//   pb_hit_cnt          (PB_STATS_EN only) saturating count of hits
//   pb_flush_cnt        (PB_STATS_EN only) saturating count of redirects and mismatches
// Optional feature macro: PB_STATS_EN
module instr_prefetch_buffer #(
    parameter int          DEPTH     = 4,
    parameter int          ADDR_STEP = 2,
    parameter logic [17:0] RESET_PC  = 18'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fe_pb_req,
    input  logic [17:0] fe_pb_pc,
    input  logic        fe_pb_redirect,
    output logic        pb_fe_valid,
    output logic [31:0] pb_fe_instr,
    output logic        pb_mc_en,
    output logic [17:0] pb_mc_addr,
    input  logic [31:0] mc_pb_data,
    input  logic        mc_pb_ack,
    input  logic        mem_pb_busy
`ifdef PB_STATS_EN
    ,
    output logic [15:0] pb_hit_cnt,
    output logic [15:0] pb_flush_cnt
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t        state_q, state_d;
    logic [17:0]   addr_q [DEPTH];
    logic [17:0]   addr_d [DEPTH];
    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   instr_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          en_q, en_d;
    logic [17:0]   mc_addr_q, mc_addr_d, fill_addr_q, fill_addr_d;
    logic          empty, hit, flush, push, can_start;

    always_comb begin
        empty = count_q == '0;
        hit   = fe_pb_req & ~fe_pb_redirect & ~empty & (addr_q[rd_ptr_q] == fe_pb_pc);
        // When empty, the next instruction to arrive is at fill_addr; asking for anything else is a discontinuity
        flush = fe_pb_redirect | (fe_pb_req & (empty ? (fill_addr_q != fe_pb_pc) : (addr_q[rd_ptr_q] != fe_pb_pc)));
        // Data acked in DROP, or acked in the same cycle as a flush, is stale and never stored
        push        = (state_q == REQ) & mc_pb_ack & ~flush;
        rd_ptr_d    = flush ? '0 : rd_ptr_q + PW'(hit);
        wr_ptr_d    = flush ? '0 : wr_ptr_q + PW'(push);
        count_d     = flush ? '0 : count_q + CW'(push) - CW'(hit);
        fill_addr_d = flush ? fe_pb_pc : fill_addr_q + (push ? 18'(ADDR_STEP) : 18'd0);
        // count_d already includes this cycle's push/pop; the new request needs one free slot
        can_start   = (count_d < CW'(DEPTH)) & ~mem_pb_busy;
        for (int i = 0; i < DEPTH; i++) begin
            addr_d[i]  = (push && wr_ptr_q == PW'(i)) ? mc_addr_q  : addr_q[i];
            instr_d[i] = (push && wr_ptr_q == PW'(i)) ? mc_pb_data : instr_q[i];
        end
        state_d   = state_q;
        en_d      = en_q;
        mc_addr_d = mc_addr_q;
        case (state_q)
            IDLE: begin
                state_d   = can_start ? REQ : IDLE;
                en_d      = can_start;
                mc_addr_d = can_start ? fill_addr_d : mc_addr_q;
            end
            REQ, DROP: begin
                if (mc_pb_ack) begin
                    state_d   = can_start ? REQ : IDLE;
                    en_d      = can_start;
                    mc_addr_d = can_start ? fill_addr_d : mc_addr_q;
                end else if (flush) begin
                    state_d = DROP;
                end
            end
            default: begin
                state_d = IDLE;
                en_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            en_q        <= 1'b0;
            mc_addr_q   <= '0;
            fill_addr_q <= RESET_PC;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i]  <= '0;
                instr_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            en_q        <= en_d;
            mc_addr_q   <= mc_addr_d;
            fill_addr_q <= fill_addr_d;
            addr_q      <= addr_d;
            instr_q     <= instr_d;
        end
    end

    assign pb_fe_valid = hit;
    assign pb_fe_instr = hit ? instr_q[rd_ptr_q] : '0;
    assign pb_mc_en    = en_q;
    assign pb_mc_addr  = mc_addr_q;

`ifdef PB_STATS_EN
    logic [15:0] hit_cnt_q, hit_cnt_d, flush_cnt_q, flush_cnt_d;

    always_comb begin
        hit_cnt_d   = hit_cnt_q + 16'(hit & ~&hit_cnt_q);
        flush_cnt_d = flush_cnt_q + 16'(flush & ~&flush_cnt_q);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hit_cnt_q   <= '0;
            flush_cnt_q <= '0;
        end else begin
            hit_cnt_q   <= hit_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign pb_hit_cnt   = hit_cnt_q;
    assign pb_flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// tb_instr_prefetch_buffer: directed scoreboard bench for the instruction prefetch buffer
module tb_instr_prefetch_buffer;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        fe_pb_req = 1'b0;
    logic [17:0] fe_pb_pc = '0;
    logic        fe_pb_redirect = 1'b0;
    logic        pb_fe_valid;
    logic [31:0] pb_fe_instr;
    logic        pb_mc_en;
    logic [17:0] pb_mc_addr;
    logic [31:0] mc_pb_data = '0;
    logic        mc_pb_ack = 1'b0;
    logic        mem_pb_busy = 1'b0;
`ifdef PB_STATS_EN
    logic [15:0] pb_hit_cnt, pb_flush_cnt;
`endif

    int          n_pass = 0;
    int          n_total = 0;
    int          lat = 0;
    logic        mc_hold = 1'b0;
    logic        seen;
    logic [17:0] exp_q [$];

    always #5 clock = ~clock;

    instr_prefetch_buffer dut (
        .clock          (clock),
        .reset          (reset),
        .fe_pb_req      (fe_pb_req),
        .fe_pb_pc       (fe_pb_pc),
        .fe_pb_redirect (fe_pb_redirect),
        .pb_fe_valid    (pb_fe_valid),
        .pb_fe_instr    (pb_fe_instr),
        .pb_mc_en       (pb_mc_en),
        .pb_mc_addr     (pb_mc_addr),
        .mc_pb_data     (mc_pb_data),
        .mc_pb_ack      (mc_pb_ack),
        .mem_pb_busy    (mem_pb_busy)
`ifdef PB_STATS_EN
        ,
        .pb_hit_cnt     (pb_hit_cnt),
        .pb_flush_cnt   (pb_flush_cnt)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [17:0] a);
        return {~a[15:0], 14'h0, a[17:16]} ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic expect_reqs(input logic [17:0] a, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(a + 18'(2 * i));
    endtask

    task automatic settle(input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            step();
            done = (exp_q.size() == 0) && !pb_mc_en;
        end
        chk({tag, "_settle"}, 32'(done), 1);
    endtask

    task automatic fetch(input string tag, input logic [17:0] pc, input logic red, input logic exp_v);
        step();
        fe_pb_req      = 1'b1;
        fe_pb_pc       = pc;
        fe_pb_redirect = red;
        #1;
        chk({tag, "_valid"}, 32'(pb_fe_valid), 32'(exp_v));
        chk({tag, "_instr"}, pb_fe_instr, exp_v ? mem_word(pc) : 32'h0);
    endtask

    // Memory controller model: acks two cycles after a request is presented; each ack is checked against the expected address
    initial forever begin
        @(negedge clock);
        if (!reset) begin
            mc_pb_ack = 1'b0;
            lat = 0;
        end else begin
            if (mc_pb_ack) begin
                mc_pb_ack = 1'b0;
                lat = 0;
            end
            if (pb_mc_en && !mc_hold) begin
                lat++;
                if (lat == 2) begin
                    lat = 0;
                    mc_pb_ack = 1'b1;
                    mc_pb_data = mem_word(pb_mc_addr);
                    chk("mc_req_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) chk("mc_addr", 32'(pb_mc_addr), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        step();
        step();
        chk("rst_en", 32'(pb_mc_en), 0);
        chk("rst_addr", 32'(pb_mc_addr), 0);
        chk("rst_valid", 32'(pb_fe_valid), 0);
        chk("rst_instr", pb_fe_instr, 0);
        expect_reqs(18'h0, 4);
        reset = 1'b1;
        step();
        chk("first_en", 32'(pb_mc_en), 1);
        chk("first_addr", 32'(pb_mc_addr), 0);
        settle("cold_fill");
        chk("full_en", 32'(pb_mc_en), 0);

        expect_reqs(18'h8, 3);
        fetch("hit0", 18'h0, 1'b0, 1'b1);
        fetch("hit2", 18'h2, 1'b0, 1'b1);
        fetch("hit4", 18'h4, 1'b0, 1'b1);
        step();
        fe_pb_req = 1'b0;
        settle("refill");

        expect_reqs(18'he, 1);
        expect_reqs(18'h100, 4);
        fetch("hit6", 18'h6, 1'b0, 1'b1);
        fetch("redir", 18'h100, 1'b1, 1'b0);
        step();
        fe_pb_req = 1'b0;
        fe_pb_redirect = 1'b0;
        chk("drop_en", 32'(pb_mc_en), 1);
        chk("drop_addr", 32'(pb_mc_addr), 32'h0e);
        settle("redir");

        expect_reqs(18'h108, 1);
        mem_pb_busy = 1'b1;
        fetch("hit100", 18'h100, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            fe_pb_req = 1'b0;
            chk("busy_idle_en", 32'(pb_mc_en), 0);
        end
        mem_pb_busy = 1'b0;
        step();
        chk("busy_release_en", 32'(pb_mc_en), 1);
        chk("busy_release_addr", 32'(pb_mc_addr), 32'h108);
        mem_pb_busy = 1'b1;
        mc_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("busy_req_en", 32'(pb_mc_en), 1);
        end
        mem_pb_busy = 1'b0;
        mc_hold = 1'b0;
        settle("busy");

        expect_reqs(18'h6, 4);
        fetch("mismatch", 18'h6, 1'b0, 1'b0);
        step();
        fe_pb_req = 1'b0;
        chk("mismatch_en", 32'(pb_mc_en), 1);
        chk("mismatch_addr", 32'(pb_mc_addr), 32'h6);
        settle("mismatch");

        expect_reqs(18'he, 1);
        expect_reqs(18'h8, 4);
        fetch("hit6b", 18'h6, 1'b0, 1'b1);
        step();
        fe_pb_req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            step();
            seen = mc_pb_ack;
        end
        chk("ackredir_seen", 32'(seen), 1);
        fe_pb_req = 1'b1;
        fe_pb_pc = 18'h8;
        fe_pb_redirect = 1'b1;
        #1;
        chk("ackredir_valid", 32'(pb_fe_valid), 0);
        step();
        fe_pb_req = 1'b0;
        fe_pb_redirect = 1'b0;
        chk("ackredir_en", 32'(pb_mc_en), 1);
        chk("ackredir_addr", 32'(pb_mc_addr), 32'h8);
        settle("ackredir");
        fetch("hit8", 18'h8, 1'b0, 1'b1);

        step();
        fe_pb_req = 1'b0;
        chk("mid_req_en", 32'(pb_mc_en), 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_en", 32'(pb_mc_en), 0);
        chk("mid_rst_addr", 32'(pb_mc_addr), 0);
        step();
        step();
        expect_reqs(18'h0, 4);
        reset = 1'b1;
        settle("rst2");

        expect_reqs(18'h3fffc, 4);
        fetch("wrap_redir", 18'h3fffc, 1'b1, 1'b0);
        step();
        fe_pb_req = 1'b0;
        fe_pb_redirect = 1'b0;
        chk("wrap_addr", 32'(pb_mc_addr), 32'h3fffc);
        settle("wrap");
        expect_reqs(18'h4, 3);
        fetch("hit3fffc", 18'h3fffc, 1'b0, 1'b1);
        fetch("hit3fffe", 18'h3fffe, 1'b0, 1'b1);
        fetch("hit0_wrap", 18'h0, 1'b0, 1'b1);
        step();
        fe_pb_req = 1'b0;
        settle("wrap_refill");
`ifdef PB_STATS_EN
        chk("hit_cnt", 32'(pb_hit_cnt), 3);
        chk("flush_cnt", 32'(pb_flush_cnt), 1);
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
